// File: rtl/push_key_event_unit_if.sv
// Host-side event port of push_key_event_unit: FWFT event FIFO head,
// pop/clear strobes, occupancy, overflow flag and interrupt level.
interface push_key_event_unit_if;
    logic       ev_valid;
    logic [7:0] ev_data;
    logic       ev_pop;
    logic [4:0] ev_count;
    logic       ev_overflow;
    logic       ov_clr;
    logic       INT;

    modport master (
        output ev_valid,
        output ev_data,
        output ev_count,
        output ev_overflow,
        output INT,
        input  ev_pop,
        input  ov_clr
    );

    modport slave (
        input  ev_valid,
        input  ev_data,
        input  ev_count,
        input  ev_overflow,
        input  INT,
        output ev_pop,
        output ov_clr
    );
endinterface

// File: rtl/push_key_event_unit.sv
// Push-key conditioning: per-key 2-flop sync and debounce, press/release
// edge capture, lowest-index arbitration into an FWFT event FIFO for the host.
module push_key_event_unit #(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int FIFO_DEPTH   = 8,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [N_KEYS-1:0]     PUSH_SW,
    output logic [N_KEYS-1:0]     key_level,
    output logic [N_KEYS-1:0]     key_press,
    push_key_event_unit_if.master ev
);

    localparam int               CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int               AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic             RELEASED = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [N_KEYS-1:0] edge_c;
    logic [N_KEYS-1:0] level_new;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic             sync1_q, sync2_q;
            logic             stable_q, stable_d;
            logic             press_q;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             s;

            // Normalised so that 1 always means pressed.
            assign s = sync2_q ^ ACTIVE_LOW;
            assign edge_c[gi]    = (s != stable_q) && (cnt_q == CNT_LAST);
            assign level_new[gi] = s;
            assign key_level[gi] = stable_q;
            assign key_press[gi] = press_q;

            always_comb begin
                stable_d = stable_q;
                cnt_d    = cnt_q;
                if (s == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = s;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (RESET) begin
                    sync1_q  <= RELEASED;
                    sync2_q  <= RELEASED;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                    press_q  <= 1'b0;
                end else begin
                    sync1_q  <= PUSH_SW[gi];
                    sync2_q  <= sync1_q;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                    press_q  <= edge_c[gi] & s;
                end
            end
        end
    endgenerate

    // Pending edge flags, drained lowest index first, one per cycle.
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [N_KEYS-1:0] ptype_q, ptype_d;
    logic [N_KEYS-1:0] grant;
    logic              push_req;
    logic              push_type;
    logic [2:0]        push_idx;
    logic              found;
    logic [7:0]        push_data;

    always_comb begin
        grant     = '0;
        push_idx  = '0;
        push_type = 1'b0;
        found     = 1'b0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (pend_q[k] && !found) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                push_idx  = 3'(k);
                push_type = ptype_q[k];
            end
        end
        push_req  = found;
        push_data = {push_type, 4'b0000, push_idx};
        pend_d    = (pend_q & ~grant) | edge_c;
        ptype_d   = (ptype_q & ~edge_c) | (level_new & edge_c);
    end

    // Event FIFO: array storage with asynchronous head read for FWFT.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop_ok, push_ok, drop;

    always_comb begin
        empty   = (cnt_q == 5'd0);
        full    = (cnt_q == 5'(FIFO_DEPTH));
        pop_ok  = ev.ev_pop && !empty;
        push_ok = push_req && (!full || pop_ok);
        drop    = push_req && full && !pop_ok;
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 5'd1;
            2'b01:   cnt_d = cnt_q - 5'd1;
            default: cnt_d = cnt_q;
        endcase
        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ev.ov_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            pend_q  <= '0;
            ptype_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !RESET) begin
            mem[wr_q] <= push_data;
        end
    end

    assign ev.ev_valid    = !empty;
    assign ev.INT         = !empty;
    assign ev.ev_data     = empty ? 8'h00 : mem[rd_q];
    assign ev.ev_count    = cnt_q;
    assign ev.ev_overflow = ovf_q;

endmodule

// File: tb/tb_push_key_event_unit.sv
// Directed bench for push_key_event_unit (N_KEYS=4, DEBOUNCE_CYC=16,
// FIFO_DEPTH=8, active-low keys) with hand-computed expected values.
module tb_push_key_event_unit;

    localparam int NK = 4;
    localparam int DB = 16;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          RESET = 1'b1;
    logic [NK-1:0] PUSH_SW = 4'hF;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;

    push_key_event_unit_if ev_if ();

    push_key_event_unit #(
        .N_KEYS      (NK),
        .DEBOUNCE_CYC(DB),
        .FIFO_DEPTH  (FD),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .RESET    (RESET),
        .PUSH_SW  (PUSH_SW),
        .key_level(key_level),
        .key_press(key_press),
        .ev       (ev_if.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'h0, ev_if.ev_data}, {24'h0, exp});
        ev_if.ev_pop = 1'b1;
        tick(1);
        ev_if.ev_pop = 1'b0;
    endtask

    logic [7:0] drain_exp [8];
    logic       bounce_seen;

    initial begin
        ev_if.ev_pop = 1'b0;
        ev_if.ov_clr = 1'b0;

        // Reset and idle
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(100);
        check("idle_level", key_level, 4'b0000);
        check("idle_press", key_press, 4'b0000);
        check("idle_valid", ev_if.ev_valid, 1'b0);
        check("idle_int",   ev_if.INT, 1'b0);
        check("idle_count", ev_if.ev_count, 5'd0);
        check("idle_data",  ev_if.ev_data, 8'h00);
        check("idle_ovf",   ev_if.ev_overflow, 1'b0);
        ev_if.ev_pop = 1'b1;
        tick(1);
        ev_if.ev_pop = 1'b0;
        check("pop_empty_count", ev_if.ev_count, 5'd0);

        // Clean press of key 2: level after 18 cycles, event one cycle later
        PUSH_SW[2] = 1'b0;
        tick(17);
        check("k2_level_17", key_level, 4'b0000);
        tick(1);
        check("k2_level_18", key_level, 4'b0100);
        check("k2_press_18", key_press, 4'b0100);
        check("k2_valid_18", ev_if.ev_valid, 1'b0);
        tick(1);
        check("k2_press_19", key_press, 4'b0000);
        check("k2_valid",    ev_if.ev_valid, 1'b1);
        check("k2_int",      ev_if.INT, 1'b1);
        check("k2_data",     ev_if.ev_data, 8'h82);
        check("k2_count",    ev_if.ev_count, 5'd1);
        ev_if.ev_pop = 1'b1;
        tick(1);
        ev_if.ev_pop = 1'b0;
        check("k2_popped_valid", ev_if.ev_valid, 1'b0);
        check("k2_popped_int",   ev_if.INT, 1'b0);
        PUSH_SW[2] = 1'b1;
        tick(19);
        check("k2_rel_level", key_level, 4'b0000);
        check("k2_rel_press", key_press, 4'b0000);
        pop_check("k2_rel_data", 8'h02);

        // Key 1 bounces, then settles pressed
        bounce_seen = 1'b0;
        for (int r = 0; r < 4; r++) begin
            PUSH_SW[1] = 1'b0;
            for (int c = 0; c < 5; c++) begin
                tick(1);
                bounce_seen = bounce_seen | ev_if.ev_valid | key_level[1];
            end
            PUSH_SW[1] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                bounce_seen = bounce_seen | ev_if.ev_valid | key_level[1];
            end
        end
        check("bounce_quiet", bounce_seen, 1'b0);
        PUSH_SW[1] = 1'b0;
        tick(17);
        check("k1_level_17", key_level, 4'b0000);
        tick(1);
        check("k1_level_18", key_level, 4'b0010);
        tick(1);
        check("k1_count", ev_if.ev_count, 5'd1);
        pop_check("k1_data", 8'h81);
        PUSH_SW[1] = 1'b1;
        tick(19);
        check("k1_rel_level", key_level, 4'b0000);
        check("k1_rel_count", ev_if.ev_count, 5'd1);
        pop_check("k1_rel_data", 8'h01);

        // Keys 0 and 3 together: drain in index order
        PUSH_SW = 4'b0110;
        tick(18);
        check("k03_level", key_level, 4'b1001);
        tick(1);
        check("k03_count_1", ev_if.ev_count, 5'd1);
        check("k03_head_1",  ev_if.ev_data, 8'h80);
        tick(1);
        check("k03_count_2", ev_if.ev_count, 5'd2);
        pop_check("k03_first",  8'h80);
        pop_check("k03_second", 8'h83);
        check("k03_empty", ev_if.ev_valid, 1'b0);
        PUSH_SW = 4'hF;
        tick(22);
        check("k03_rel_count", ev_if.ev_count, 5'd2);
        pop_check("k03_rel_first",  8'h00);
        pop_check("k03_rel_second", 8'h03);

        // Ten events without popping: last two dropped
        PUSH_SW = 4'h0;
        tick(24);
        check("ovf_count_4", ev_if.ev_count, 5'd4);
        PUSH_SW = 4'hF;
        tick(24);
        check("ovf_count_8", ev_if.ev_count, 5'd8);
        check("ovf_not_yet", ev_if.ev_overflow, 1'b0);
        PUSH_SW = 4'b1100;
        tick(24);
        check("ovf_level",   key_level, 4'b0011);
        check("ovf_count",   ev_if.ev_count, 5'd8);
        check("ovf_flag",    ev_if.ev_overflow, 1'b1);
        check("ovf_head",    ev_if.ev_data, 8'h80);
        ev_if.ov_clr = 1'b1;
        tick(1);
        ev_if.ov_clr = 1'b0;
        check("ovf_cleared", ev_if.ev_overflow, 1'b0);

        // Push and pop together while full
        PUSH_SW = 4'hF;
        tick(18);
        ev_if.ev_pop = 1'b1;
        tick(1);
        check("full_pp_count_1", ev_if.ev_count, 5'd8);
        check("full_pp_head_1",  ev_if.ev_data, 8'h81);
        tick(1);
        ev_if.ev_pop = 1'b0;
        check("full_pp_count_2", ev_if.ev_count, 5'd8);
        check("full_pp_head_2",  ev_if.ev_data, 8'h82);
        check("full_pp_ovf",     ev_if.ev_overflow, 1'b0);
        drain_exp[0] = 8'h82; drain_exp[1] = 8'h83;
        drain_exp[2] = 8'h00; drain_exp[3] = 8'h01;
        drain_exp[4] = 8'h02; drain_exp[5] = 8'h03;
        drain_exp[6] = 8'h00; drain_exp[7] = 8'h01;
        for (int i = 0; i < 8; i++) begin
            pop_check($sformatf("drain_%0d", i), drain_exp[i]);
        end
        check("drain_empty", ev_if.ev_valid, 1'b0);

        // Reset with keys held and three queued events
        PUSH_SW = 4'b1000;
        tick(24);
        check("pre_rst_count", ev_if.ev_count, 5'd3);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        check("rst_count", ev_if.ev_count, 5'd0);
        check("rst_valid", ev_if.ev_valid, 1'b0);
        check("rst_int",   ev_if.INT, 1'b0);
        check("rst_level", key_level, 4'b0000);
        check("rst_data",  ev_if.ev_data, 8'h00);
        tick(17);
        check("rst_level_17", key_level, 4'b0000);
        check("rst_count_17", ev_if.ev_count, 5'd0);
        tick(1);
        check("rst_level_18", key_level, 4'b0111);
        tick(1);
        check("rst_requeue_count", ev_if.ev_count, 5'd1);
        check("rst_requeue_data",  ev_if.ev_data, 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
